// File: rtl/tetris_yigin.sv
// Column-stack tracker: each accepted piece mask adds one cell per selected column; after
// CEVRIM_SAYISI accepts the tallest column is reported. Define SATIR_SIL_EN for full-row clearing.
module tetris_yigin #(
  parameter  int SUTUN         = 3,
  parameter  int CEVRIM_SAYISI = 16,
  parameter  int YW            = 5,
  localparam int CW            = $clog2(CEVRIM_SAYISI + 1),
  localparam int SW            = $clog2(SUTUN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             basla,
  input  logic             parca_gecerli,
  input  logic [SUTUN-1:0] parca,
  output logic [YW-1:0]    yukseklik,
  output logic [SW-1:0]    en_sutun,
  output logic [CW-1:0]    cevrim,
  output logic             bitti_mi,
  output logic [YW-1:0]    silinen
);

  typedef enum logic [1:0] {BOSTA, OYUN, HESAP, BITTI} state_t;

  localparam logic [YW-1:0] HMAX = '1;

  state_t                      state_q, state_d;
  logic [SUTUN-1:0][YW-1:0]    h_q, h_d;
  logic [CW-1:0]               cev_q, cev_d;
  logic [YW-1:0]               yuk_q, yuk_d;
  logic [SW-1:0]               en_q, en_d;
  logic [YW-1:0]               sil_q, sil_d;

  logic [SUTUN-1:0][YW-1:0]    h_add, h_acc;
  logic [YW-1:0]               sil_acc;
  logic [YW-1:0]               mx;
  logic [SW-1:0]               mi;

  // Saturating add, then optional full-row clear on the same edge.
  always_comb begin
    for (int i = 0; i < SUTUN; i++)
      h_add[i] = (parca[i] && h_q[i] != HMAX) ? h_q[i] + 1'b1 : h_q[i];
`ifdef SATIR_SIL_EN
    begin
      logic tam;
      tam = 1'b1;
      for (int i = 0; i < SUTUN; i++)
        if (h_add[i] == '0) tam = 1'b0;
      for (int i = 0; i < SUTUN; i++)
        h_acc[i] = tam ? h_add[i] - 1'b1 : h_add[i];
      sil_acc = (tam && sil_q != HMAX) ? sil_q + 1'b1 : sil_q;
    end
`else
    h_acc   = h_add;
    sil_acc = '0;
`endif
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    mx = h_q[0];
    mi = '0;
    for (int i = 1; i < SUTUN; i++)
      if (h_q[i] > mx) begin
        mx = h_q[i];
        mi = SW'(i);
      end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cev_d   = cev_q;
    yuk_d   = yuk_q;
    en_d    = en_q;
    sil_d   = sil_q;
    case (state_q)
      BOSTA, BITTI: begin
        if (basla) begin
          h_d     = '0;
          cev_d   = '0;
          sil_d   = '0;
          state_d = OYUN;
        end
      end
      OYUN: begin
        if (parca_gecerli) begin
          h_d   = h_acc;
          cev_d = cev_q + 1'b1;
          sil_d = sil_acc;
          if (cev_q == CW'(CEVRIM_SAYISI - 1)) state_d = HESAP;
        end
      end
      HESAP: begin
        yuk_d   = mx;
        en_d    = mi;
        state_d = BITTI;
      end
      default: state_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOSTA;
      h_q     <= '0;
      cev_q   <= '0;
      yuk_q   <= '0;
      en_q    <= '0;
      sil_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cev_q   <= cev_d;
      yuk_q   <= yuk_d;
      en_q    <= en_d;
      sil_q   <= sil_d;
    end
  end

  assign yukseklik = yuk_q;
  assign en_sutun  = en_q;
  assign cevrim    = cev_q;
  assign bitti_mi  = (state_q == BITTI);
  assign silinen   = sil_q;

endmodule

// File: tb/tb_tetris_yigin.sv
// Randomized bench for tetris_yigin: a default-width instance and a YW=3 instance share
// the same stimulus and are checked against a piece-list reference model.
module tb_tetris_yigin;

`ifdef SATIR_SIL_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, basla, pv;
  logic [2:0] parca;
  logic [4:0] yuk, cev, sil;
  logic [1:0] en;
  logic       bit5;
  logic [2:0] yuk3, sil3;
  logic [4:0] cev3;
  logic [1:0] en3;
  logic       bit3;

  int checks = 0;
  int failures = 0;
  int pq[$];

  always #5 clk = ~clk;

  tetris_yigin u_dut (
    .clk(clk), .rst_n(rst_n), .basla(basla), .parca_gecerli(pv), .parca(parca),
    .yukseklik(yuk), .en_sutun(en), .cevrim(cev), .bitti_mi(bit5), .silinen(sil)
  );

  tetris_yigin #(.YW(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .basla(basla), .parca_gecerli(pv), .parca(parca),
    .yukseklik(yuk3), .en_sutun(en3), .cevrim(cev3), .bitti_mi(bit3), .silinen(sil3)
  );

  // Replays the whole piece list from empty columns.
  function automatic void model(input int yw, output int mx, output int ix, output int sl);
    int h[3];
    int top;
    top = (1 << yw) - 1;
    h   = '{0, 0, 0};
    sl  = 0;
    foreach (pq[k]) begin
      for (int i = 0; i < 3; i++) begin
        int b;
        b = (pq[k] >> i) & 1;
        h[i] = (h[i] + b > top) ? top : h[i] + b;
      end
      if (CLR && h[0] > 0 && h[1] > 0 && h[2] > 0) begin
        for (int i = 0; i < 3; i++) h[i] = h[i] - 1;
        if (sl < top) sl = sl + 1;
      end
    end
    mx = 0;
    ix = 0;
    for (int i = 0; i < 3; i++)
      if (h[i] > mx) begin
        mx = h[i];
        ix = i;
      end
  endfunction

  // Starts a game and feeds pq; returns #1 after the final accept edge.
  task automatic play(input int gapmode);
    @(posedge clk); #1;
    basla = 1'b1; pv = 1'b0; parca = 3'($urandom);
    @(posedge clk); #1;
    basla = 1'b0;
    foreach (pq[k]) begin
      if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 2) == 0)) begin
        pv = 1'b0; parca = 3'($urandom);
        @(posedge clk); #1;
      end
      pv = 1'b1; parca = 3'(pq[k]);
      @(posedge clk); #1;
    end
    pv = 1'b0; parca = 3'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; basla = 1'b0; pv = 1'b0; parca = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({yuk, en, cev, bit5, sil} !== '0) begin
      failures++;
      $display("FAIL reset5 got yuk=%0d en=%0d cev=%0d bitti=%0b sil=%0d want all 0", yuk, en, cev, bit5, sil);
    end
    checks++;
    if ({yuk3, en3, cev3, bit3, sil3} !== '0) begin
      failures++;
      $display("FAIL reset3 got yuk=%0d en=%0d cev=%0d bitti=%0b sil=%0d want all 0", yuk3, en3, cev3, bit3, sil3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_col();
    int mx, ix, sl, mx3, ix3, sl3;
    pq = {};
    repeat (16) pq.push_back(1);
    model(5, mx, ix, sl);
    model(3, mx3, ix3, sl3);
    play(0);
    checks++;
    if (cev !== 5'd16 || bit5 !== 1'b0) begin
      failures++;
      $display("FAIL single_hesap got cev=%0d bitti=%0b want 16/0", cev, bit5);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bit5 !== 1'b1 || yuk !== 5'(mx) || en !== 2'(ix) || yuk !== 5'd16 || en !== 2'd0) begin
      failures++;
      $display("FAIL single_res got bitti=%0b yuk=%0d en=%0d want 1/%0d/%0d", bit5, yuk, en, mx, ix);
    end
    checks++;
    if (bit3 !== 1'b1 || yuk3 !== 3'(mx3) || en3 !== 2'(ix3) || sil3 !== 3'(sl3)) begin
      failures++;
      $display("FAIL single_res3 got bitti=%0b yuk=%0d en=%0d sil=%0d want 1/%0d/%0d/%0d", bit3, yuk3, en3, sil3, mx3, ix3, sl3);
    end
  endtask

  task automatic test_gaps();
    int mx, ix, sl;
    pq = {};
    repeat (16) pq.push_back(6);
    model(5, mx, ix, sl);
    play(1);
    checks++;
    if (cev !== 5'd16 || bit5 !== 1'b0) begin
      failures++;
      $display("FAIL gaps_hesap got cev=%0d bitti=%0b want 16/0", cev, bit5);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bit5 !== 1'b1 || yuk !== 5'(mx) || en !== 2'(ix) || en !== 2'd1) begin
      failures++;
      $display("FAIL gaps_res got bitti=%0b yuk=%0d en=%0d want 1/%0d/%0d", bit5, yuk, en, mx, ix);
    end
  endtask

  task automatic test_saturation();
    int mx, ix, sl, mx3, ix3, sl3;
    pq = {};
    repeat (16) pq.push_back(4);
    model(5, mx, ix, sl);
    model(3, mx3, ix3, sl3);
    play(2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bit3 !== 1'b1 || yuk3 !== 3'(mx3) || en3 !== 2'(ix3) || yuk3 !== 3'd7 || en3 !== 2'd2) begin
      failures++;
      $display("FAIL sat3 got bitti=%0b yuk=%0d en=%0d want 1/%0d/%0d", bit3, yuk3, en3, mx3, ix3);
    end
    checks++;
    if (yuk !== 5'(mx) || en !== 2'(ix)) begin
      failures++;
      $display("FAIL sat5 got yuk=%0d en=%0d want %0d/%0d", yuk, en, mx, ix);
    end
  endtask

  task automatic test_abort();
    pq = {};
    repeat (5) pq.push_back(int'($urandom_range(1, 7)));
    play(0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bit5 !== 1'b0 || cev !== '0 || yuk !== '0 || cev3 !== '0) begin
      failures++;
      $display("FAIL abort got bitti=%0b cev=%0d yuk=%0d cev3=%0d want 0", bit5, cev, yuk, cev3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      pv = 1'b1; parca = 3'($urandom);
      @(posedge clk); #1;
    end
    pv = 1'b0;
    checks++;
    if (cev !== '0 || bit5 !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore got cev=%0d bitti=%0b want 0/0", cev, bit5);
    end
  endtask

  task automatic test_back_to_back();
    int mx, ix, sl;
    logic [4:0] old;
    pq = {};
    repeat (16) pq.push_back(int'($urandom_range(0, 7)));
    model(5, mx, ix, sl);
    play(2);
    repeat (2) @(posedge clk);
    #1;
    old = 5'(mx);
    checks++;
    if (bit5 !== 1'b1 || yuk !== old || en !== 2'(ix) || sil !== 5'(sl)) begin
      failures++;
      $display("FAIL b2b_first got bitti=%0b yuk=%0d en=%0d sil=%0d want 1/%0d/%0d/%0d", bit5, yuk, en, sil, mx, ix, sl);
    end
    basla = 1'b1;
    @(posedge clk); #1;
    basla = 1'b0;
    checks++;
    if (bit5 !== 1'b0 || cev !== '0 || sil !== '0 || yuk !== old) begin
      failures++;
      $display("FAIL restart got bitti=%0b cev=%0d sil=%0d yuk=%0d want 0/0/0/%0d", bit5, cev, sil, yuk, old);
    end
    for (int g = 0; g < 6; g++) begin
      pq = {};
      repeat (16) pq.push_back(int'($urandom_range(0, 7)));
      model(5, mx, ix, sl);
      play(2);
      checks++;
      if (bit5 !== 1'b0 || cev !== 5'd16) begin
        failures++;
        $display("FAIL rand_hesap g=%0d got bitti=%0b cev=%0d want 0/16", g, bit5, cev);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bit5 !== 1'b1 || yuk !== 5'(mx) || en !== 2'(ix) || sil !== 5'(sl)) begin
        failures++;
        $display("FAIL rand_res g=%0d got bitti=%0b yuk=%0d en=%0d sil=%0d want 1/%0d/%0d/%0d", g, bit5, yuk, en, sil, mx, ix, sl);
      end
    end
  endtask

  task automatic test_line_clear();
    int mx, ix, sl, mx3, ix3, sl3;
    pq = {};
    repeat (16) pq.push_back(7);
    model(5, mx, ix, sl);
    model(3, mx3, ix3, sl3);
    play(0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bit5 !== 1'b1 || yuk !== 5'(mx) || en !== 2'(ix) || sil !== 5'(sl)) begin
      failures++;
      $display("FAIL clear5 got bitti=%0b yuk=%0d en=%0d sil=%0d want 1/%0d/%0d/%0d", bit5, yuk, en, sil, mx, ix, sl);
    end
    checks++;
    if (yuk3 !== 3'(mx3) || en3 !== 2'(ix3) || sil3 !== 3'(sl3)) begin
      failures++;
      $display("FAIL clear3 got yuk=%0d en=%0d sil=%0d want %0d/%0d/%0d", yuk3, en3, sil3, mx3, ix3, sl3);
    end
  endtask

  initial begin
    test_reset();
    test_single_col();
    test_gaps();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_line_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
